// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select and path metric unit for a hard-decision rate-1/2, K=3 Viterbi decoder.
// Updates four normalised, saturated path metrics and survivor decisions per valid symbol.
module viterbi_acs_pmu #(
  parameter int unsigned PM_W = 2,
  parameter logic [2:0]  G0   = 3'b111,
  parameter logic [2:0]  G1   = 3'b101
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_start,
  input  logic [1:0]      i_rx_sym,
  output logic [PM_W-1:0] o_PM_0,
  output logic [PM_W-1:0] o_PM_1,
  output logic [PM_W-1:0] o_PM_2,
  output logic [PM_W-1:0] o_PM_3,
  output logic [3:0]      o_dec,
  output logic            o_valid
);

  // Two guard bits: PM_MAX plus a branch metric of 2 can never overflow.
  localparam int unsigned CW = PM_W + 2;
  localparam logic [PM_W-1:0] PmMax = {PM_W{1'b1}};
  localparam logic [3:0][PM_W-1:0] PmInit = {PmMax, PmMax, PmMax, {PM_W{1'b0}}};

  logic [3:0][PM_W-1:0] pm_q, pm_d;
  logic [3:0]           dec_q, dec_d;
  logic                 valid_q;

  logic [3:0][CW-1:0]   sel;
  logic [CW-1:0]        cand0, cand1, min01, min23, min_all, norm;
  logic [1:0]           nst, p0, p1;

  // Hamming distance between the received symbol and the code bits of branch s --u-->.
  function automatic logic [1:0] bm_f(input logic u, input logic [1:0] s, input logic [1:0] sym);
    logic [2:0] us;
    logic [1:0] diff;
    us   = {u, s};
    diff = sym ^ {^(us & G1), ^(us & G0)};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  always_comb begin
    sel   = '0;
    dec_d = '0;
    nst   = '0;
    p0    = '0;
    p1    = '0;
    cand0 = '0;
    cand1 = '0;
    for (int n = 0; n < 4; n++) begin
      nst   = 2'(n);
      p0    = {nst[0], 1'b0};
      p1    = {nst[0], 1'b1};
      cand0 = CW'(pm_q[p0]) + CW'(bm_f(nst[1], p0, i_rx_sym));
      cand1 = CW'(pm_q[p1]) + CW'(bm_f(nst[1], p1, i_rx_sym));
      if (cand1 < cand0) begin
        sel[n]   = cand1;
        dec_d[n] = 1'b1;
      end else begin
        sel[n]   = cand0;
        dec_d[n] = 1'b0;
      end
    end
  end

  always_comb begin
    min01   = (sel[1] < sel[0]) ? sel[1] : sel[0];
    min23   = (sel[3] < sel[2]) ? sel[3] : sel[2];
    min_all = (min23 < min01) ? min23 : min01;
    pm_d    = '0;
    norm    = '0;
    for (int n = 0; n < 4; n++) begin
      norm    = sel[n] - min_all;
      pm_d[n] = (norm > CW'(PmMax)) ? PmMax : norm[PM_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pm_q    <= PmInit;
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_start) begin
      pm_q    <= PmInit;
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_valid) begin
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign o_PM_0  = pm_q[0];
  assign o_PM_1  = pm_q[1];
  assign o_PM_2  = pm_q[2];
  assign o_PM_3  = pm_q[3];
  assign o_dec   = dec_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_viterbi_acs_pmu.sv
// Directed self-checking bench for viterbi_acs_pmu; expected metrics worked out by hand
// from the trellis (c0 = u^s1^s0, c1 = u^s0, i_rx_sym = {c1,c0}).
module tb_viterbi_acs_pmu;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       i_start;
  logic [1:0] i_rx_sym;
  logic [1:0] o_PM_0, o_PM_1, o_PM_2, o_PM_3;
  logic [3:0] o_dec;
  logic       o_valid;
  logic [7:0] pms;

  int n_tests;
  int n_fail;

  viterbi_acs_pmu #(
    .PM_W(2),
    .G0  (3'b111),
    .G1  (3'b101)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_start (i_start),
    .i_rx_sym(i_rx_sym),
    .o_PM_0  (o_PM_0),
    .o_PM_1  (o_PM_1),
    .o_PM_2  (o_PM_2),
    .o_PM_3  (o_PM_3),
    .o_dec   (o_dec),
    .o_valid (o_valid)
  );

  assign pms = {o_PM_0, o_PM_1, o_PM_2, o_PM_3};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic s, input logic [1:0] sym);
    i_valid  = v;
    i_start  = s;
    i_rx_sym = sym;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_start  = 1'b0;
  endtask

  // Called 1 unit after a rising edge; releases reset between edges.
  task automatic do_reset();
    i_valid = 1'b0;
    i_start = 1'b0;
    i_rst_n = 1'b0;
    #4;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd3, 2'd3}) begin
      n_fail++;
      $display("FAIL reset_pm: got %h, want %h", pms, {2'd0, 2'd3, 2'd3, 2'd3});
    end
    n_tests++;
    if (o_dec !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_dec: got %b, want 0000", o_dec);
    end
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b, want 0", o_valid);
    end
  endtask

  task automatic test_sym00();
    do_reset();
    step(1'b1, 1'b0, 2'b00);
    n_tests++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sym00_valid: got %b, want 1", o_valid);
    end
    // S1 and S3 reach 4 and saturate to 3.
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd2, 2'd3}) begin
      n_fail++;
      $display("FAIL sym00_pm: got %h, want %h", pms, {2'd0, 2'd3, 2'd2, 2'd3});
    end
    n_tests++;
    if (o_dec !== 4'b0000) begin
      n_fail++;
      $display("FAIL sym00_dec: got %b, want 0000", o_dec);
    end
  endtask

  task automatic test_sym11();
    do_reset();
    step(1'b1, 1'b0, 2'b11);
    n_tests++;
    if (pms !== {2'd2, 2'd3, 2'd0, 2'd3}) begin
      n_fail++;
      $display("FAIL sym11_pm: got %h, want %h", pms, {2'd2, 2'd3, 2'd0, 2'd3});
    end
    n_tests++;
    if (o_dec !== 4'b0000) begin
      n_fail++;
      $display("FAIL sym11_dec: got %b, want 0000", o_dec);
    end
  endtask

  // i_rx_sym = 2'b01 means c1=0, c0=1: from {2,3,0,3} gives raw {3,0,3,2}.
  task automatic test_bit_order();
    do_reset();
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b01);
    n_tests++;
    if (pms !== {2'd3, 2'd0, 2'd3, 2'd2}) begin
      n_fail++;
      $display("FAIL bitorder_pm: got %h, want %h", pms, {2'd3, 2'd0, 2'd3, 2'd2});
    end
    n_tests++;
    if (o_dec !== 4'b0000) begin
      n_fail++;
      $display("FAIL bitorder_dec: got %b, want 0000", o_dec);
    end
  endtask

  // Code symbol c0=0, c1=1 is i_rx_sym = {c1,c0} = 2'b10.
  task automatic test_sequence();
    do_reset();
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    n_tests++;
    if (pms !== {2'd3, 2'd2, 2'd3, 2'd0}) begin
      n_fail++;
      $display("FAIL seq_pm2: got %h, want %h", pms, {2'd3, 2'd2, 2'd3, 2'd0});
    end
    step(1'b1, 1'b0, 2'b00);
    // raw {3,1,2,1} normalises to {2,0,1,0}
    n_tests++;
    if (pms !== {2'd2, 2'd0, 2'd1, 2'd0}) begin
      n_fail++;
      $display("FAIL seq_pm3: got %h, want %h", pms, {2'd2, 2'd0, 2'd1, 2'd0});
    end
    n_tests++;
    if (o_dec !== 4'b1110) begin
      n_fail++;
      $display("FAIL seq_dec3: got %b, want 1110", o_dec);
    end
    step(1'b0, 1'b0, 2'b11);
    n_tests++;
    if (o_dec !== 4'b1110 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_hold_dec: got dec=%b valid=%b, want dec=1110 valid=0", o_dec, o_valid);
    end
    n_tests++;
    if (pms !== {2'd2, 2'd0, 2'd1, 2'd0}) begin
      n_fail++;
      $display("FAIL seq_hold_pm: got %h, want %h", pms, {2'd2, 2'd0, 2'd1, 2'd0});
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'($urandom_range(3)));
      n_tests++;
      if (pms !== {2'd0, 2'd3, 2'd2, 2'd3} || o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: got pm=%h valid=%b, want pm=%h valid=0",
                 i, pms, o_valid, {2'd0, 2'd3, 2'd2, 2'd3});
      end
    end
  endtask

  task automatic test_start();
    do_reset();
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b11);
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd3, 2'd3}) begin
      n_fail++;
      $display("FAIL start_pm: got %h, want %h", pms, {2'd0, 2'd3, 2'd3, 2'd3});
    end
    n_tests++;
    if (o_dec !== 4'b0000 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ctl: got dec=%b valid=%b, want dec=0000 valid=0", o_dec, o_valid);
    end
    step(1'b1, 1'b0, 2'b00);
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd2, 2'd3} || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_after: got pm=%h valid=%b, want pm=%h valid=1",
               pms, o_valid, {2'd0, 2'd3, 2'd2, 2'd3});
    end
    // start without valid also re-initialises
    step(1'b0, 1'b1, 2'b01);
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd3, 2'd3} || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_novalid: got pm=%h valid=%b, want pm=%h valid=0",
               pms, o_valid, {2'd0, 2'd3, 2'd3, 2'd3});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b00);
    i_valid  = 1'b1;
    i_rx_sym = 2'b00;
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd3, 2'd3} || o_dec !== 4'b0000 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got pm=%h dec=%b valid=%b, want pm=%h dec=0000 valid=0",
               pms, o_dec, o_valid, {2'd0, 2'd3, 2'd3, 2'd3});
    end
    i_valid = 1'b0;
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    step(1'b1, 1'b0, 2'b00);
    n_tests++;
    if (pms !== {2'd0, 2'd3, 2'd2, 2'd3} || o_dec !== 4'b0000 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_resume: got pm=%h dec=%b valid=%b, want pm=%h dec=0000 valid=1",
               pms, o_dec, o_valid, {2'd0, 2'd3, 2'd2, 2'd3});
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_start  = 1'b0;
    i_rx_sym = 2'b00;
    @(posedge i_clk);
    #1;
    test_reset();
    test_sym00();
    test_sym11();
    test_bit_order();
    test_sequence();
    test_hold();
    test_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
